// File: rtl/crpa_coef_loader.sv
// crpa_coef_loader: double-buffered FIR coefficient loader for the CRPA null former.
// Words are streamed into a shadow register. A complete shadow set is swapped onto
// the active coefficient bus only on a frame tick, so the null former never sees
// a half-updated set.
module crpa_coef_loader #(
    parameter int NCH      = 4,
    parameter int NT       = 7,
    parameter int NCFWIDTH = 12,
    localparam int K       = (NCH - 1) * NT,
    localparam int CW      = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    input  logic [NCFWIDTH-1:0]   wr_data,
    output logic                  wr_ready,
    input  logic                  wr_abort,
    input  logic                  commit_en,
    output logic [K*NCFWIDTH-1:0] coeffs_concat,
    output logic                  coef_upd,
    output logic                  full,
    output logic [CW-1:0]         wr_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
    logic [K*NCFWIDTH-1:0]   shadow_q;
    logic [K*NCFWIDTH-1:0]   coeffs_q;
    logic                    wr_ready_q, wr_ready_d;
    logic                    full_q, full_d;
    logic                    coef_upd_q, coef_upd_d;
    logic                    xfer;
    logic                    swap_go;

    // Abort dominates both a simultaneous word and a simultaneous commit.
    assign xfer    = (state_q == ST_LOAD) && wr_valid && !wr_abort;
    assign swap_go = (state_q == ST_FULL) && commit_en && !wr_abort;

    // State and word-counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_LOAD;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Next-state logic; commit in LOAD is ignored, so a final word arriving
    // with commit_en still has to wait for a later tick seen in FULL.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (wr_abort) begin
                    wr_cnt_d = '0;
                end else if (xfer) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == CW'(K - 1)) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (wr_abort) begin
                    state_d  = ST_LOAD;
                    wr_cnt_d = '0;
                end else if (swap_go) begin
                    state_d  = ST_SWAP;
                    wr_cnt_d = '0;
                end
            end
            ST_SWAP: begin
                state_d  = ST_LOAD;
                wr_cnt_d = '0;
            end
            default: begin
                state_d  = ST_LOAD;
                wr_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags are registered with it.
    always_comb begin
        wr_ready_d = (state_d == ST_LOAD);
        full_d     = (state_d == ST_FULL);
        coef_upd_d = (state_d == ST_SWAP);
    end

    // Registered handshake and status flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ready_q <= 1'b1;
            full_q     <= 1'b0;
            coef_upd_q <= 1'b0;
        end else begin
            wr_ready_q <= wr_ready_d;
            full_q     <= full_d;
            coef_upd_q <= coef_upd_d;
        end
    end

    // Shadow store: word n lands in slot n, bit-exact, no sign handling.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_q <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (xfer && (wr_cnt_q == CW'(i))) begin
                    shadow_q[i*NCFWIDTH +: NCFWIDTH] <= wr_data;
                end
            end
        end
    end

    // Active bus changes only on the swap; it holds its value otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            coeffs_q <= '0;
        end else if (swap_go) begin
            coeffs_q <= shadow_q;
        end
    end

    assign wr_ready      = wr_ready_q;
    assign full          = full_q;
    assign coef_upd      = coef_upd_q;
    assign wr_cnt        = wr_cnt_q;
    assign coeffs_concat = coeffs_q;

endmodule

// File: tb/tb_crpa_coef_loader.sv
// tb_crpa_coef_loader: table-driven bench for crpa_coef_loader with a result queue.
module tb_crpa_coef_loader;

    localparam int NCH = 4;
    localparam int NT  = 7;
    localparam int W   = 12;
    localparam int K   = (NCH - 1) * NT;
    localparam int CW  = $clog2(K + 1);
    localparam int BW  = K * W;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic          wr_abort;
    logic          commit_en;
    logic [BW-1:0] coeffs_concat;
    logic          coef_upd;
    logic          full;
    logic [CW-1:0] wr_cnt;

    crpa_coef_loader #(.NCH(NCH), .NT(NT), .NCFWIDTH(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .wr_abort      (wr_abort),
        .commit_en     (commit_en),
        .coeffs_concat (coeffs_concat),
        .coef_upd      (coef_upd),
        .full          (full),
        .wr_cnt        (wr_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        bit           rstn;
        bit           valid;
        logic [W-1:0] data;
        bit           abort;
        bit           commit;
        bit           eReady;
        bit           eFull;
        bit           eUpd;
        int           eCnt;
    } vec_t;

    typedef struct {
        bit            ready;
        bit            fullFlag;
        bit            upd;
        int            cnt;
        logic [BW-1:0] bus;
    } exp_t;

    vec_t          vecs[$];
    exp_t          sb[$];
    logic [W-1:0]  mShadow [K];
    logic [BW-1:0] mActive;
    bit            mReady;
    int            mCnt;
    int            nCompared;
    int            nMismatched;

    task automatic addVec(input bit rstn, input bit valid, input logic [W-1:0] data,
                          input bit abort, input bit commit, input bit eReady,
                          input bit eFull, input bit eUpd, input int eCnt);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.data = data; v.abort = abort; v.commit = commit;
        v.eReady = eReady; v.eFull = eFull; v.eUpd = eUpd; v.eCnt = eCnt;
        vecs.push_back(v);
    endtask

    // Back-to-back load from an empty shadow; mode 0 ramps from base,
    // mode 1 repeats base, mode 2 alternates 0x7FF / 0x800.
    task automatic addLoad(input int nWords, input int mode, input logic [W-1:0] base,
                           input bit commitLast);
        logic [W-1:0] d;
        for (int i = 0; i < nWords; i++) begin
            if (mode == 0)      d = base + W'(i);
            else if (mode == 1) d = base;
            else                d = (i % 2 == 0) ? 12'h7FF : 12'h800;
            if (i + 1 == K)
                addVec(1, 1, d, 0, commitLast && (i == nWords - 1), 0, 1, 0, i + 1);
            else
                addVec(1, 1, d, 0, commitLast && (i == nWords - 1), 1, 0, 0, i + 1);
        end
    endtask

    task automatic cmp(input string name, input int idx, input logic [BW-1:0] act,
                       input logic [BW-1:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            $display("[TB] FAIL v%0d %s: got %0h expected %0h", idx, name, act, expv);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        resetn    = v.rstn;
        wr_valid  = v.valid;
        wr_data   = v.data;
        wr_abort  = v.abort;
        commit_en = v.commit;
        if (!v.rstn) begin
            for (int i = 0; i < K; i++) mShadow[i] = '0;
            mActive = '0;
        end else begin
            if (v.valid && !v.abort && mReady && (mCnt < K)) mShadow[mCnt] = v.data;
            if (v.eUpd) begin
                for (int i = 0; i < K; i++) mActive[i*W +: W] = mShadow[i];
            end
        end
        e.ready = v.eReady; e.fullFlag = v.eFull; e.upd = v.eUpd; e.cnt = v.eCnt;
        e.bus = mActive;
        sb.push_back(e);
        mReady = v.eReady;
        mCnt   = v.eCnt;
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL v%0d queue: got empty expected entry", idx);
        end else begin
            e = sb.pop_front();
            cmp("wr_ready", idx, BW'(wr_ready), BW'(e.ready));
            cmp("full", idx, BW'(full), BW'(e.fullFlag));
            cmp("coef_upd", idx, BW'(coef_upd), BW'(e.upd));
            cmp("wr_cnt", idx, BW'(wr_cnt), BW'(e.cnt));
            cmp("coeffs_concat", idx, coeffs_concat, e.bus);
        end
    endtask

    initial begin
        resetn = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_abort = 1'b0; commit_en = 1'b0;
        nCompared = 0; nMismatched = 0; mReady = 1'b0; mCnt = 0; mActive = '0;
        for (int i = 0; i < K; i++) mShadow[i] = '0;

        // Reset state.
        addVec(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Full ramp load 1..K, idle in FULL, commit, then back to LOAD.
        addLoad(K, 0, 12'h001, 0);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, K);
        addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Partial load: commit has no effect, count survives, abort clears it.
        addLoad(10, 0, 12'h100, 0);
        addVec(1, 0, 0, 0, 1, 1, 0, 0, 10);
        addVec(1, 0, 0, 0, 0, 1, 0, 0, 10);
        addVec(1, 0, 0, 1, 0, 1, 0, 0, 0);
        // Abort with a word offered, then a full load of -5 and commit.
        addLoad(12, 0, 12'h200, 0);
        addVec(1, 1, 12'h3AA, 1, 0, 1, 0, 0, 0);
        addLoad(K, 1, 12'hFFB, 0);
        addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Abort beats commit in FULL; a later commit in LOAD does nothing.
        addLoad(K, 0, 12'h600, 0);
        addVec(1, 0, 0, 1, 1, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 1, 0, 0, 0);
        // Commit with the final word is ignored; words in FULL are refused;
        // commit three cycles later swaps; abort during SWAP is ignored.
        addLoad(K, 0, 12'h040, 1);
        addVec(1, 1, 12'h555, 0, 0, 0, 1, 0, K);
        addVec(1, 1, 12'h555, 0, 0, 0, 1, 0, K);
        addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(1, 1, 12'h0AA, 1, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Alternating extremes, commit, then a one-cycle reset.
        addLoad(K, 2, 12'h000, 0);
        addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Reset landing in the SWAP cycle clears the active bus.
        addLoad(K, 0, 12'h700, 0);
        addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Reset in FULL discards the set; a following commit does nothing.
        addLoad(K, 0, 12'h300, 0);
        addVec(0, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 1, 0, 0, 0);
        addLoad(K, 0, 12'h900, 0);
        addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 1, 0, 0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n]);
            @(posedge clk);
            #1;
            checkOutput(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/crpa_coef_loader.md
CRPA_COEF_LOADER -- requirements
Module: crpa_coef_loader

Interface
REQ-001 Parameter NCH, default 4, number of null-former inputs; coefficient sets = NCH-1.
REQ-002 Parameter NT, default 7, taps per FIR filter.
REQ-003 Parameter NCFWIDTH, default 12, signed coefficient width.
REQ-004 Derived K = (NCH-1)*NT (21 at defaults); CW = CLOG2(K+1).
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 wr_valid  input  1  coefficient word offered.
REQ-008 wr_data  input  NCFWIDTH  coefficient word.
REQ-009 wr_ready  output  1  loader accepts wr_data this cycle.
REQ-010 wr_abort  input  1  discard the partial shadow load.
REQ-011 commit_en  input  1  single-cycle swap opportunity (frame tick).
REQ-012 coeffs_concat  output  K*NCFWIDTH  active coefficient bus for the null former.
REQ-013 coef_upd  output  1  one-cycle pulse, new active set valid.
REQ-014 full  output  1  shadow holds a complete set awaiting commit.
REQ-015 wr_cnt  output  CW  words accepted into the current shadow load.

Function
REQ-016 A transfer shall occur on a cycle with wr_valid=1, wr_ready=1 and wr_abort=0.
REQ-017 Word number i (0-based, in transfer order) shall be stored in shadow bits [(i+1)*NCFWIDTH-1 : i*NCFWIDTH]; word 0 is filter 1 tap 0, word NT is filter 2 tap 0.
REQ-018 The FSM shall have three states: LOAD, FULL, SWAP.
REQ-019 LOAD: wr_ready=1; each transfer increments wr_cnt; the transfer that makes wr_cnt reach K shall move the FSM to FULL on the next cycle.
REQ-020 FULL: wr_ready=0, full=1; wr_valid is ignored; commit_en=1 shall move the FSM to SWAP.
REQ-021 SWAP: coeffs_concat shall be loaded with the shadow register; coef_upd=1 for exactly this cycle; wr_cnt shall clear to 0; the FSM returns to LOAD on the next cycle.
REQ-022 Latency: new coefficients shall be visible on coeffs_concat, with coef_upd high, exactly one cycle after the commit_en cycle sampled in FULL.
REQ-023 commit_en in LOAD, including a partially loaded shadow, shall have no effect.
REQ-024 A final-word transfer with commit_en high in the same cycle shall not swap; the swap waits for the next commit_en seen in FULL.
REQ-025 wr_abort=1 in LOAD or FULL shall clear wr_cnt to 0, set full to 0, and put the FSM in LOAD; coeffs_concat shall be unchanged.
REQ-026 wr_abort has priority over a simultaneous transfer (the word is dropped) and over commit_en in FULL (no swap).
REQ-027 wr_abort during SWAP shall be ignored; the swap completes.
REQ-028 coeffs_concat shall change only in SWAP and shall hold its value otherwise.
REQ-029 Shadow words shall be stored bit-exact, with no sign handling or arithmetic.
REQ-030 All outputs shall be registered.

Reset
REQ-031 While resetn=0 on a clock edge: FSM in LOAD, coeffs_concat=0, shadow=0, wr_cnt=0, full=0, coef_upd=0, wr_ready=1 on the following cycle.
REQ-032 Reset mid-load or in FULL shall discard the shadow contents.
REQ-033 Reset in SWAP shall leave coeffs_concat=0.

Verification
REQ-034 Load words 1..21 back-to-back, then a commit_en pulse -> full=1 after word 21; next cycle coeffs_concat word i = i+1; coef_upd high for one cycle; wr_cnt=0.
REQ-035 Load 10 words, then commit_en -> no coef_upd; coeffs_concat unchanged; wr_cnt=10; wr_ready=1.
REQ-036 Load 12 words, wr_abort with wr_valid high, then load 21 words of -5 (0xFFB) and commit -> all 21 active words are 0xFFB; the aborted word is not stored.
REQ-037 21st word with commit_en high in the same cycle -> no swap; a commit_en 3 cycles later swaps; wr_valid offered in FULL is not accepted (wr_ready=0).
REQ-038 Full load and commit of pattern 0x7FF/0x800 alternating, then resetn low for 1 cycle -> coeffs_concat=0, wr_ready=1, full=0.
